avalon_sram_responder: RTL and testbench
========================================

Name: avalon_sram_responder

Overview:
- Avalon-MM target (responder) fronting an on-chip word-addressed RAM; it is the far end of the accelerator's DMA initiator port (avm_*).
- Serves single-word reads and writes with a programmable number of wait states, driven through avs_waitrequest.
- Terminates out-of-range or illegal accesses cleanly so a DMA never hangs, and counts them for debug.

Parameters:
- ADDR_WIDTH, 10: word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2: wait states inserted before each acknowledge; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte base address of the RAM window; must be 4-byte aligned.
- ERR_DATA, 32'hDEAD_BEEF: readdata returned for an erroneous access.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- avs_read  input  1  read request; held by the initiator until acknowledged.
- avs_write  input  1  write request; held by the initiator until acknowledged.
- avs_address  input  32  byte address; held with the request.
- avs_writedata  input  32  write data; held with the request.
- avs_readdata  output  32  read data; valid in the acknowledge cycle.
- avs_waitrequest  output  1  high = transfer not accepted; low for exactly one cycle per transfer.
- err_flag  output  1  sticky error indicator.
- err_count  output  16  saturating count of erroneous accesses.
- err_clear  input  1  synchronous clear of err_flag and err_count.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, avs_waitrequest=1, avs_readdata=0, err_flag=0, err_count=0, wait counter=0.
  - RAM contents are not reset.
  - A transfer in flight when reset asserts is abandoned: no RAM write, no acknowledge.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: avs_waitrequest=1.
    - If avs_read|avs_write: capture address, writedata and request type; load counter=WAIT_CYCLES.
    - Go to WAIT, or directly to ACK when WAIT_CYCLES=0.
  - WAIT: avs_waitrequest=1.
    - Counter decrements each cycle; when counter==1, next state is ACK.
    - If the initiator drops both avs_read and avs_write (protocol violation): abort to IDLE, no RAM write, no error counted.
  - ACK: avs_waitrequest=0 for exactly this one cycle; always returns to IDLE next cycle.
- Latency: request first sampled in IDLE at edge T; avs_waitrequest low during cycle T+1+WAIT_CYCLES; next request is sampled no earlier than the cycle after ACK. Back-to-back transfers therefore cost WAIT_CYCLES+2 cycles each.
- Decode:
  - word index = (captured_addr - BASE_ADDR) >> 2.
  - Error if captured_addr < BASE_ADDR, or captured_addr >= BASE_ADDR + 4*2**ADDR_WIDTH, or captured_addr[1:0] != 0, or avs_read and avs_write were both high at capture.
  - Address arithmetic is 32-bit unsigned and must not wrap.
- Read:
  - avs_readdata is registered on the edge entering ACK: RAM[index], or ERR_DATA on error.
  - Holds its value until the next read acknowledge; writes do not change it.
- Write:
  - RAM[index] <= captured writedata on the edge entering ACK; discarded on error.
  - A read issued after a write's ACK returns the new data.
- Error accounting:
  - On the edge entering ACK for an erroneous access: err_flag<=1; err_count increments, saturating at 16'hFFFF.
  - err_clear has priority over a simultaneous increment: both go to 0.
- Request signal changes during WAIT other than a full drop are ignored; the captured values are used.

Test Plan:
- WAIT_CYCLES=2: write 32'h1234_5678 to address 0x10, then read 0x10 -> waitrequest low exactly at T+3 for each transfer; readdata=32'h1234_5678; err_count=0.
- WAIT_CYCLES=0: emulate the DMA pattern, i.e. read 0x0 then 0x4 with avs_read held continuously after preloading 32'hA5A5_0001 and 32'hA5A5_0002 -> two acknowledges 2 cycles apart returning those values in order.
- Read address BASE_ADDR+4*2**ADDR_WIDTH (0x1000 with defaults) and address 0x2 -> each acknowledged, readdata=32'hDEAD_BEEF; err_flag=1; err_count=2.
- Write 32'hFFFF_FFFF to 0x1000 (out of range) -> acknowledged, no RAM change: a read of 0x0 returns its prior value; err_count increments by 1.
- Assert reset_n=0 during WAIT of a write to 0x20 holding 32'h0BAD_0BAD -> waitrequest=1 and readdata=0 immediately, no acknowledge; after reset, reading 0x20 returns its pre-reset value.
- Preload err_count=16'hFFFF by forcing, then an erroneous access -> err_count stays 16'hFFFF; with err_clear high on the ACK edge -> err_count=0, err_flag=0.

Source files
------------

// File: rtl/avalon_sram_responder_if.sv
// Avalon-MM bus bundle between a DMA initiator and the SRAM responder.
// The initiator drives the request fields; the responder drives readdata and waitrequest.
interface avalon_sram_responder_if;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_address;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_read,
    output avs_write,
    output avs_address,
    output avs_writedata,
    input  avs_readdata,
    input  avs_waitrequest
  );

  modport slave (
    input  avs_read,
    input  avs_write,
    input  avs_address,
    input  avs_writedata,
    output avs_readdata,
    output avs_waitrequest
  );
endinterface

// File: rtl/avalon_sram_responder.sv
// Avalon-MM responder in front of a word-addressed on-chip RAM with programmable wait states.
// Bad accesses are still acknowledged, so a DMA initiator never stalls, and they are counted for debug.
module avalon_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  avalon_sram_responder_if.slave        avs,
  output logic                          err_flag,
  output logic [15:0]                   err_count,
  input  logic                          err_clear
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] readdata_q;
  logic        errFlag_q;
  logic [15:0] errCount_q;

  logic [31:0] mem [DEPTH];

  logic                  effRead;
  logic                  effWrite;
  logic [31:0]           effAddr;
  logic [31:0]           effWdata;
  logic [32:0]           diff;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic                  accErr;
  logic                  goAck;

  // With zero wait states the ACK edge is also the capture edge, so the
  // live bus is decoded in IDLE and the captured copy everywhere else.
  always_comb begin
    effRead  = avs.avs_read;
    effWrite = avs.avs_write;
    effAddr  = avs.avs_address;
    effWdata = avs.avs_writedata;
    if (state_q != IDLE) begin
      effRead  = read_q;
      effWrite = write_q;
      effAddr  = addr_q;
      effWdata = wdata_q;
    end
  end

  // 33-bit subtraction: the borrow bit flags addresses below the window.
  always_comb begin
    diff    = {1'b0, effAddr} - {1'b0, BASE_ADDR};
    wordIdx = ADDR_WIDTH'(diff >> 2);
    accErr  = diff[32]
            | ({1'b0, effAddr} >= LIMIT)
            | (effAddr[1:0] != 2'b00)
            | (effRead & effWrite);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (avs.avs_read | avs.avs_write) begin
          addr_d  = avs.avs_address;
          wdata_d = avs.avs_writedata;
          read_d  = avs.avs_read;
          write_d = avs.avs_write;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!avs.avs_read && !avs.avs_write) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign goAck = (state_d == ACK) && (state_q != ACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  // Read data only moves on a read acknowledge; writes leave it untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= 32'd0;
    end else if (goAck && effRead) begin
      readdata_q <= accErr ? ERR_DATA : mem[wordIdx];
    end
  end

  always_ff @(posedge clk) begin
    if (goAck && effWrite && !accErr) begin
      mem[wordIdx] <= effWdata;
    end
  end

  // Clear wins over a simultaneous error so software never misses a reset of the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      errFlag_q  <= 1'b0;
      errCount_q <= 16'd0;
    end else if (err_clear) begin
      errFlag_q  <= 1'b0;
      errCount_q <= 16'd0;
    end else if (goAck && accErr) begin
      errFlag_q <= 1'b1;
      if (errCount_q != 16'hFFFF) begin
        errCount_q <= errCount_q + 16'd1;
      end
    end
  end

  assign avs.avs_waitrequest = (state_q != ACK);
  assign avs.avs_readdata    = readdata_q;
  assign err_flag            = errFlag_q;
  assign err_count           = errCount_q;

endmodule

// File: tb/tb_avalon_sram_responder.sv
// Self-checking bench for avalon_sram_responder: a vector table plus hand sequences,
// with a scoreboard that checks every acknowledge against the expected read data.
module tb_avalon_sram_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        errClear;
  logic        errFlag;
  logic [15:0] errCount;
  logic        errClear0;
  logic        errFlag0;
  logic [15:0] errCount0;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  avalon_sram_responder_if bus ();
  avalon_sram_responder_if bus0 ();

  avalon_sram_responder #(
    .ADDR_WIDTH (10),
    .WAIT_CYCLES(W),
    .BASE_ADDR  (32'h0000_0000),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .err_flag (errFlag),
    .err_count(errCount),
    .err_clear(errClear)
  );

  avalon_sram_responder #(
    .ADDR_WIDTH (10),
    .WAIT_CYCLES(0),
    .BASE_ADDR  (32'h0000_0000),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus0),
    .err_flag (errFlag0),
    .err_count(errCount0),
    .err_clear(errClear0)
  );

  typedef struct {
    logic        isRead;
    logic [31:0] data;
  } sbEntry_t;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRead;
    logic [15:0] expErrCount;
    logic        expErrFlag;
  } vector_t;

  sbEntry_t    sbQ[$];
  logic [31:0] lastReadExp = 32'd0;
  vector_t     vec[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every acknowledge must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sbEntry_t e;
    if (reset_n === 1'b1 && bus.avs_waitrequest === 1'b0) begin
      if (sbQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_ack: got ack, expected none");
      end else begin
        e = sbQ.pop_front();
        checkOutput(e.isRead ? "ack_readdata" : "ack_hold_readdata", bus.avs_readdata, e.data);
      end
    end
  end

  // Called on a negedge with the DUT idle; returns on the negedge after the bus goes quiet.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRead,
                               input int clrAt, input logic chg, input logic [31:0] chgAddr);
    sbEntry_t e;
    int       n;
    bit       acked;
    bus.avs_read      = rd;
    bus.avs_write     = wr;
    bus.avs_address   = addr;
    bus.avs_writedata = wdata;
    e.isRead = rd;
    e.data   = rd ? expRead : lastReadExp;
    if (rd) lastReadExp = expRead;
    sbQ.push_back(e);
    acked = 0;
    n     = 0;
    while (!acked && n < 30) begin
      @(negedge clk);
      n++;
      if (bus.avs_waitrequest === 1'b0) acked = 1;
      if (chg && n == 1) bus.avs_address = chgAddr;
      if (clrAt == n) errClear = 1'b1;
    end
    checkOutput("ack_latency", 32'(n), 32'(W + 1));
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
    errClear      = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec[0]  = '{"wr_0x10",      1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,          16'd0, 1'b0};
    vec[1]  = '{"rd_0x10",      1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'h1234_5678, 16'd0, 1'b0};
    vec[2]  = '{"wr_0x0",       1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_0000,  32'h0,          16'd0, 1'b0};
    vec[3]  = '{"wr_last",      1'b0, 1'b1, 32'h0000_0FFC, 32'h7777_7777,  32'h0,          16'd0, 1'b0};
    vec[4]  = '{"rd_0x1000",    1'b1, 1'b0, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 16'd1, 1'b1};
    vec[5]  = '{"rd_unaligned", 1'b1, 1'b0, 32'h0000_0002, 32'h0,          32'hDEAD_BEEF, 16'd2, 1'b1};
    vec[6]  = '{"wr_0x1000",    1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF,  32'h0,          16'd3, 1'b1};
    vec[7]  = '{"rd_0x0",       1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'hCAFE_0000, 16'd3, 1'b1};
    vec[8]  = '{"rd_top",       1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'hDEAD_BEEF, 16'd4, 1'b1};
    vec[9]  = '{"rdwr_both",    1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF,  32'hDEAD_BEEF, 16'd5, 1'b1};
    vec[10] = '{"rd_0x10_again",1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'h1234_5678, 16'd5, 1'b1};
    vec[11] = '{"rd_last",      1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          32'h7777_7777, 16'd5, 1'b1};
    vec[12] = '{"wr_0x20",      1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222,  32'h0,          16'd5, 1'b1};

    reset_n = 1'b0;
    errClear = 1'b0;
    errClear0 = 1'b0;
    bus.avs_read = 1'b0;  bus.avs_write = 1'b0;  bus.avs_address = 32'd0;  bus.avs_writedata = 32'd0;
    bus0.avs_read = 1'b0; bus0.avs_write = 1'b0; bus0.avs_address = 32'd0; bus0.avs_writedata = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_waitrequest", 32'(bus.avs_waitrequest), 32'd1);
    checkOutput("rst_readdata", bus.avs_readdata, 32'd0);
    checkOutput("rst_err_flag", 32'(errFlag), 32'd0);
    checkOutput("rst_err_count", 32'(errCount), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Zero-wait DMA pattern: request held across two transfers, acks two cycles apart.
    bus0.avs_write = 1'b1; bus0.avs_address = 32'h0; bus0.avs_writedata = 32'hA5A5_0001;
    @(negedge clk);
    checkOutput("dma_wr0_ack", 32'(bus0.avs_waitrequest), 32'd0);
    bus0.avs_address = 32'h4; bus0.avs_writedata = 32'hA5A5_0002;
    @(negedge clk);
    checkOutput("dma_wr_gap", 32'(bus0.avs_waitrequest), 32'd1);
    @(negedge clk);
    checkOutput("dma_wr1_ack", 32'(bus0.avs_waitrequest), 32'd0);
    bus0.avs_write = 1'b0;
    @(negedge clk);
    bus0.avs_read = 1'b1; bus0.avs_address = 32'h0;
    @(negedge clk);
    checkOutput("dma_rd0_ack", 32'(bus0.avs_waitrequest), 32'd0);
    checkOutput("dma_rd0_data", bus0.avs_readdata, 32'hA5A5_0001);
    bus0.avs_address = 32'h4;
    @(negedge clk);
    checkOutput("dma_rd_gap", 32'(bus0.avs_waitrequest), 32'd1);
    @(negedge clk);
    checkOutput("dma_rd1_ack", 32'(bus0.avs_waitrequest), 32'd0);
    checkOutput("dma_rd1_data", bus0.avs_readdata, 32'hA5A5_0002);
    bus0.avs_read = 1'b0;
    @(negedge clk);
    checkOutput("dma_err_count", 32'(errCount0), 32'd0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].expRead, 0, 1'b0, 32'd0);
      checkOutput({vec[i].name, "_err_count"}, 32'(errCount), 32'(vec[i].expErrCount));
      checkOutput({vec[i].name, "_err_flag"}, 32'(errFlag), 32'(vec[i].expErrFlag));
    end

    // Reset in the middle of a write's wait states abandons it.
    bus.avs_write = 1'b1; bus.avs_address = 32'h20; bus.avs_writedata = 32'h0BAD_0BAD;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_waitrequest", 32'(bus.avs_waitrequest), 32'd1);
    checkOutput("mid_rst_readdata", bus.avs_readdata, 32'd0);
    checkOutput("mid_rst_err_count", 32'(errCount), 32'd0);
    lastReadExp = 32'd0;
    bus.avs_write = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_no_ack", 32'(bus.avs_waitrequest), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'd0, 32'h1111_2222, 0, 1'b0, 32'd0);

    // Initiator drops the request during WAIT: abort without ack or error.
    bus.avs_read = 1'b1; bus.avs_address = 32'h1000;
    @(negedge clk);
    bus.avs_read = 1'b0;
    begin
      int sawAck = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.avs_waitrequest === 1'b0) sawAck++;
      end
      checkOutput("abort_no_ack", 32'(sawAck), 32'd0);
    end
    checkOutput("abort_err_count", 32'(errCount), 32'd0);

    // Address change mid-WAIT is ignored; the captured in-range address is used.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 32'h1234_5678, 0, 1'b1, 32'h1000);
    checkOutput("chg_err_count", 32'(errCount), 32'd0);

    force dut.errCount_q = 16'hFFFF;
    @(negedge clk);
    release dut.errCount_q;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h3, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, 32'd0);
    checkOutput("sat_err_count", 32'(errCount), 32'hFFFF);
    checkOutput("sat_err_flag", 32'(errFlag), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'd0, 32'hDEAD_BEEF, W, 1'b0, 32'd0);
    checkOutput("clr_err_count", 32'(errCount), 32'd0);
    checkOutput("clr_err_flag", 32'(errFlag), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
